// File: rtl/shared_bus_controller.sv
// Two-core snooping bus controller: arbitrates, broadcasts to the peer, then fills from peer or L2.
// Optional build macro ROUND_ROBIN_EN: alternate ties between cores instead of fixed core-0 priority.
module shared_bus_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        c0_req,
    input  logic        c1_req,
    output logic        c0_grant,
    output logic        c1_grant,
    input  logic [1:0]  c0_bus_operation,
    input  logic [1:0]  c1_bus_operation,
    input  logic [31:0] c0_bus_address,
    input  logic [31:0] c1_bus_address,
    input  logic [31:0] c0_bus_data,
    input  logic [31:0] c1_bus_data,
    input  logic        c0_cache_hit,
    input  logic        c1_cache_hit,
    output logic [1:0]  c0_snoop_operation,
    output logic [1:0]  c1_snoop_operation,
    output logic [31:0] c0_snoop_address,
    output logic [31:0] c1_snoop_address,
    output logic [31:0] c0_snoop_data,
    output logic [31:0] c1_snoop_data,
    output logic [1:0]  c0_cache_hit_in,
    output logic [1:0]  c1_cache_hit_in,
    output logic        l2_rd_req,
    output logic [31:0] l2_address,
    input  logic        l2_rd_valid,
    input  logic [31:0] l2_rd_data
);

    typedef enum logic [2:0] {IDLE, ADDR, SNOOP, RESP, L2RD, DONE, REL} state_t;

    state_t           r_state, w_state_nx;
    logic             r_owner, w_owner_nx;
    logic [1:0]       r_grant, w_grant_nx;
    logic [1:0][1:0]  r_snp_op, w_snp_op_nx;
    logic [1:0][31:0] r_snp_addr, w_snp_addr_nx;
    logic [1:0][31:0] r_snp_data, w_snp_data_nx;
    logic [1:0][1:0]  r_hit_in, w_hit_in_nx;
    logic             r_l2_req, w_l2_req_nx;
    logic [31:0]      r_l2_addr, w_l2_addr_nx;
    logic [1:0]       r_op;
    logic [31:0]      r_addr;
    logic             w_latch;

    logic [1:0]       w_req;
    logic [1:0][1:0]  w_op;
    logic [1:0][31:0] w_addr;
    logic [1:0][31:0] w_data;
    logic [1:0]       w_hit;
    logic             w_winner;
    logic             w_peer;
    logic             w_abort;

    assign w_req  = {c1_req, c0_req};
    assign w_op   = {c1_bus_operation, c0_bus_operation};
    assign w_addr = {c1_bus_address, c0_bus_address};
    assign w_data = {c1_bus_data, c0_bus_data};
    assign w_hit  = {c1_cache_hit, c0_cache_hit};
    assign w_peer = ~r_owner;

`ifdef ROUND_ROBIN_EN
    logic r_last;

    // Starts at core 1 so the first tie after reset favours core 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_last <= 1'b1;
        else if (r_state == IDLE && |w_req)
            r_last <= w_winner;
    end

    assign w_winner = (&w_req) ? ~r_last : w_req[1];
`else
    assign w_winner = ~w_req[0];
`endif

    assign w_abort = !w_req[r_owner] &&
                     (r_state == ADDR || r_state == SNOOP || r_state == RESP || r_state == L2RD);

    always_comb begin
        w_state_nx    = r_state;
        w_owner_nx    = r_owner;
        w_grant_nx    = r_grant;
        w_snp_op_nx   = r_snp_op;
        w_snp_addr_nx = r_snp_addr;
        w_snp_data_nx = r_snp_data;
        w_hit_in_nx   = '0;
        w_l2_req_nx   = r_l2_req;
        w_l2_addr_nx  = r_l2_addr;
        w_latch       = 1'b0;

        if (w_abort) begin
            w_state_nx  = IDLE;
            w_grant_nx  = 2'b00;
            w_snp_op_nx = '1;
            w_l2_req_nx = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        w_owner_nx = w_winner;
                        w_grant_nx = w_winner ? 2'b10 : 2'b01;
                        w_state_nx = ADDR;
                    end
                end
                ADDR: begin
                    if (w_op[r_owner] != 2'b11) begin
                        w_latch               = 1'b1;
                        w_snp_op_nx[w_peer]   = w_op[r_owner];
                        w_snp_addr_nx[w_peer] = w_addr[r_owner];
                        w_snp_data_nx[w_peer] = w_data[r_owner];
                        w_state_nx            = SNOOP;
                    end
                end
                SNOOP: begin
                    w_snp_op_nx[w_peer] = 2'b11;
                    w_state_nx          = RESP;
                end
                RESP: begin
                    if (r_op == 2'b01) begin
                        w_hit_in_nx[r_owner] = 2'b11;
                        w_state_nx           = DONE;
                    end else if (w_hit[w_peer]) begin
                        w_hit_in_nx[r_owner]   = 2'b01;
                        w_snp_data_nx[r_owner] = w_data[w_peer];
                        w_state_nx             = DONE;
                    end else begin
                        w_l2_req_nx  = 1'b1;
                        w_l2_addr_nx = r_addr;
                        w_state_nx   = L2RD;
                    end
                end
                L2RD: begin
                    if (l2_rd_valid) begin
                        w_l2_req_nx            = 1'b0;
                        w_hit_in_nx[r_owner]   = 2'b10;
                        w_snp_data_nx[r_owner] = l2_rd_data;
                        w_state_nx             = DONE;
                    end
                end
                DONE: w_state_nx = REL;
                REL: begin
                    if (!w_req[r_owner]) begin
                        w_grant_nx = 2'b00;
                        w_state_nx = IDLE;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_owner    <= 1'b0;
            r_grant    <= 2'b00;
            r_snp_op   <= '1;
            r_snp_addr <= '0;
            r_snp_data <= '0;
            r_hit_in   <= '0;
            r_l2_req   <= 1'b0;
            r_l2_addr  <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_owner    <= w_owner_nx;
            r_grant    <= w_grant_nx;
            r_snp_op   <= w_snp_op_nx;
            r_snp_addr <= w_snp_addr_nx;
            r_snp_data <= w_snp_data_nx;
            r_hit_in   <= w_hit_in_nx;
            r_l2_req   <= w_l2_req_nx;
            r_l2_addr  <= w_l2_addr_nx;
        end
    end

    // Transaction operation/address are datapath only; no reset needed.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_op   <= w_op[r_owner];
            r_addr <= w_addr[r_owner];
        end
    end

    assign c0_grant           = r_grant[0];
    assign c1_grant           = r_grant[1];
    assign c0_snoop_operation = r_snp_op[0];
    assign c1_snoop_operation = r_snp_op[1];
    assign c0_snoop_address   = r_snp_addr[0];
    assign c1_snoop_address   = r_snp_addr[1];
    assign c0_snoop_data      = r_snp_data[0];
    assign c1_snoop_data      = r_snp_data[1];
    assign c0_cache_hit_in    = r_hit_in[0];
    assign c1_cache_hit_in    = r_hit_in[1];
    assign l2_rd_req          = r_l2_req;
    assign l2_address         = r_l2_addr;

endmodule

// File: tb/tb_shared_bus_controller.sv
// Bench for shared_bus_controller: table of single-core transactions plus tie, abort and reset sequences.
module tb_shared_bus_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        c0_req = 1'b0, c1_req = 1'b0;
    logic        c0_grant, c1_grant;
    logic [1:0]  c0_bus_operation = 2'b11, c1_bus_operation = 2'b11;
    logic [31:0] c0_bus_address = '0, c1_bus_address = '0;
    logic [31:0] c0_bus_data = '0, c1_bus_data = '0;
    logic        c0_cache_hit = 1'b0, c1_cache_hit = 1'b0;
    logic [1:0]  c0_snoop_operation, c1_snoop_operation;
    logic [31:0] c0_snoop_address, c1_snoop_address;
    logic [31:0] c0_snoop_data, c1_snoop_data;
    logic [1:0]  c0_cache_hit_in, c1_cache_hit_in;
    logic        l2_rd_req;
    logic [31:0] l2_address;
    logic        l2_rd_valid = 1'b0;
    logic [31:0] l2_rd_data = '0;

    int total = 0;
    int bad = 0;

    shared_bus_controller dut (
        .clk(clk), .reset(reset),
        .c0_req(c0_req), .c1_req(c1_req),
        .c0_grant(c0_grant), .c1_grant(c1_grant),
        .c0_bus_operation(c0_bus_operation), .c1_bus_operation(c1_bus_operation),
        .c0_bus_address(c0_bus_address), .c1_bus_address(c1_bus_address),
        .c0_bus_data(c0_bus_data), .c1_bus_data(c1_bus_data),
        .c0_cache_hit(c0_cache_hit), .c1_cache_hit(c1_cache_hit),
        .c0_snoop_operation(c0_snoop_operation), .c1_snoop_operation(c1_snoop_operation),
        .c0_snoop_address(c0_snoop_address), .c1_snoop_address(c1_snoop_address),
        .c0_snoop_data(c0_snoop_data), .c1_snoop_data(c1_snoop_data),
        .c0_cache_hit_in(c0_cache_hit_in), .c1_cache_hit_in(c1_cache_hit_in),
        .l2_rd_req(l2_rd_req), .l2_address(l2_address),
        .l2_rd_valid(l2_rd_valid), .l2_rd_data(l2_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          core;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        phit;
        logic [31:0] pdata;
        int          addr_wait;
        int          l2lat;
        logic [31:0] l2data;
        logic        exp_l2;
        logic [1:0]  exp_code;
        logic [31:0] exp_data;
        logic        chk_data;
    } vec_t;

    typedef struct {
        int          core;
        logic [1:0]  code;
        logic [31:0] data;
        logic        chk;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[7];

    function automatic vec_t mk(int core, logic [1:0] op, logic [31:0] addr, logic [31:0] rdata,
                                logic phit, logic [31:0] pdata, int addr_wait, int l2lat,
                                logic [31:0] l2data, logic exp_l2, logic [1:0] exp_code,
                                logic [31:0] exp_data, logic chk_data);
        vec_t v;
        v.core = core; v.op = op; v.addr = addr; v.rdata = rdata; v.phit = phit; v.pdata = pdata;
        v.addr_wait = addr_wait; v.l2lat = l2lat; v.l2data = l2data; v.exp_l2 = exp_l2;
        v.exp_code = exp_code; v.exp_data = exp_data; v.chk_data = chk_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic grant_of(int c);
        return (c == 0) ? c0_grant : c1_grant;
    endfunction
    function automatic logic [1:0] snp_op_of(int c);
        return (c == 0) ? c0_snoop_operation : c1_snoop_operation;
    endfunction
    function automatic logic [31:0] snp_addr_of(int c);
        return (c == 0) ? c0_snoop_address : c1_snoop_address;
    endfunction
    function automatic logic [31:0] snp_data_of(int c);
        return (c == 0) ? c0_snoop_data : c1_snoop_data;
    endfunction
    function automatic logic [1:0] hit_in_of(int c);
        return (c == 0) ? c0_cache_hit_in : c1_cache_hit_in;
    endfunction

    task automatic drive(input int c, input logic req, input logic [1:0] op,
                         input logic [31:0] addr, input logic [31:0] data);
        if (c == 0) begin
            c0_req = req; c0_bus_operation = op; c0_bus_address = addr; c0_bus_data = data;
        end else begin
            c1_req = req; c1_bus_operation = op; c1_bus_address = addr; c1_bus_data = data;
        end
    endtask

    task automatic set_hit(input int c, input logic hit, input logic [31:0] data);
        if (c == 0) begin
            c0_cache_hit = hit; c0_bus_data = data;
        end else begin
            c1_cache_hit = hit; c1_bus_data = data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        int   p;
        int   cyc;
        int   l2cnt;
        int   snp_cnt;
        bit   got;
        bit   req_snp_bad;
        bit   saw_l2;
        bit   both;
        exp_t e;
        p = 1 - v.core;
        l2cnt = 0; snp_cnt = 0; got = 0; req_snp_bad = 0; saw_l2 = 0; both = 0;
        drive(v.core, 1'b1, 2'b11, v.addr, v.rdata);
        set_hit(p, v.phit, v.pdata);
        l2_rd_valid = !v.exp_l2;
        l2_rd_data  = 32'hBAD0_BAD0;
        cyc = 0;
        while (!grant_of(v.core) && cyc < 20) begin
            tick();
            cyc++;
        end
        check("grant_rise", grant_of(v.core), 1);
        check("grant_excl", grant_of(p), 0);
        for (int i = 0; i < v.addr_wait; i++) tick();
        check("addr_wait_peer_idle", snp_op_of(p), 2'b11);
        drive(v.core, 1'b1, v.op, v.addr, v.rdata);
        e.core = v.core; e.code = v.exp_code; e.data = v.exp_data; e.chk = v.chk_data;
        sb_q.push_back(e);
        cyc = 0;
        while (!got && cyc < 60) begin
            tick();
            cyc++;
            l2_rd_valid = !v.exp_l2;
            if (c0_grant && c1_grant) both = 1;
            if (snp_op_of(v.core) != 2'b11) req_snp_bad = 1;
            if (snp_op_of(p) != 2'b11) begin
                snp_cnt++;
                check("snoop_op", snp_op_of(p), v.op);
                check("snoop_addr", snp_addr_of(p), v.addr);
            end
            if (l2_rd_req) begin
                saw_l2 = 1;
                l2cnt++;
                if (l2cnt == 1) check("l2_address", l2_address, v.addr);
                if (l2cnt == v.l2lat) begin
                    l2_rd_valid = 1'b1;
                    l2_rd_data  = v.l2data;
                end
            end
            if (hit_in_of(0) != 2'b00 || hit_in_of(1) != 2'b00) begin
                e = sb_q.pop_front();
                check("resp_code", hit_in_of(e.core), e.code);
                if (e.chk) check("resp_data", snp_data_of(e.core), e.data);
                got = 1;
            end
        end
        if (!got && sb_q.size() > 0) void'(sb_q.pop_front());
        check("resp_seen", got, 1);
        check("snoop_len", snp_cnt, 1);
        check("req_snoop_idle", req_snp_bad, 0);
        check("l2_req_used", saw_l2, v.exp_l2);
        check("one_grant", both, 0);
        l2_rd_valid = 1'b0;
        tick();
        check("resp_one_cycle", hit_in_of(v.core), 2'b00);
        check("grant_hold", grant_of(v.core), 1);
        drive(v.core, 1'b0, 2'b11, '0, '0);
        tick();
        check("grant_fall", grant_of(v.core), 0);
        set_hit(p, 1'b0, '0);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grants"}, {c1_grant, c0_grant}, 2'b00);
        check({tag, "_snoop_ops"}, {c1_snoop_operation, c0_snoop_operation}, 4'hF);
        check({tag, "_snoop_addr"}, c0_snoop_address | c1_snoop_address, 0);
        check({tag, "_snoop_data"}, c0_snoop_data | c1_snoop_data, 0);
        check({tag, "_hit_in"}, {c1_cache_hit_in, c0_cache_hit_in}, 4'h0);
        check({tag, "_l2_req"}, l2_rd_req, 0);
        check({tag, "_l2_addr"}, l2_address, 0);
    endtask

    task automatic tie_round(input int exp_w);
        int cyc;
        bit stray;
        stray = 0;
        drive(0, 1'b1, 2'b01, 32'h80, '0);
        drive(1, 1'b1, 2'b01, 32'h84, '0);
        cyc = 0;
        while (!(c0_grant || c1_grant) && cyc < 20) begin
            tick();
            cyc++;
        end
        check("tie_winner", {c1_grant, c0_grant}, (exp_w == 0) ? 2'b01 : 2'b10);
        drive(0, 1'b0, 2'b11, '0, '0);
        drive(1, 1'b0, 2'b11, '0, '0);
        tick();
        check("tie_abort_grant", {c1_grant, c0_grant}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (c0_cache_hit_in != 2'b00 || c1_cache_hit_in != 2'b00) stray = 1;
        end
        check("tie_no_resp", stray, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit stray;
        int cyc;
        tbl[0] = mk(0, 2'b00, 32'h0000_0040, 32'h1111_1111, 0, 32'h0BAD_CAFE, 0, 3, 32'hDEAD_BEEF, 1, 2'b10, 32'hDEAD_BEEF, 1);
        tbl[1] = mk(1, 2'b10, 32'h0000_0100, 32'h2222_2222, 1, 32'h1234_5678, 0, 0, 32'h0,         0, 2'b01, 32'h1234_5678, 1);
        tbl[2] = mk(0, 2'b01, 32'h0000_0080, 32'h0,         1, 32'h5555_5555, 0, 0, 32'h0,         0, 2'b11, 32'h0,         0);
        tbl[3] = mk(1, 2'b00, 32'h0000_0200, 32'h0,         0, 32'h6666_6666, 2, 1, 32'hCAFE_F00D, 1, 2'b10, 32'hCAFE_F00D, 1);
        tbl[4] = mk(0, 2'b10, 32'h0000_0300, 32'h0000_0077, 1, 32'hA5A5_A5A5, 1, 0, 32'h0,         0, 2'b01, 32'hA5A5_A5A5, 1);
        tbl[5] = mk(1, 2'b01, 32'h0000_03C0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         0, 2'b11, 32'h0,         0);
        tbl[6] = mk(0, 2'b10, 32'h0000_0400, 32'h0,         0, 32'h0000_0099, 0, 5, 32'h0F0F_0F0F, 1, 2'b10, 32'h0F0F_0F0F, 1);

        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Simultaneous requests right after reset.
        tie_round(0);
`ifdef ROUND_ROBIN_EN
        tie_round(1);
`else
        tie_round(0);
`endif

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Requester withdraws during the snoop broadcast.
        drive(0, 1'b1, 2'b00, 32'h40, '0);
        set_hit(1, 1'b0, '0);
        cyc = 0;
        while (!c0_grant && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        check("abort_snoop_phase", c1_snoop_operation, 2'b00);
        drive(0, 1'b0, 2'b11, '0, '0);
        tick();
        check("abort_grant_fall", c0_grant, 0);
        check("abort_snoop_idle", c1_snoop_operation, 2'b11);
        check("abort_l2_idle", l2_rd_req, 0);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (c0_cache_hit_in != 2'b00 || l2_rd_req) stray = 1;
        end
        check("abort_no_resp", stray, 0);

        // Reset asserted while waiting on L2.
        drive(0, 1'b1, 2'b00, 32'h500, '0);
        set_hit(1, 1'b0, '0);
        l2_rd_valid = 1'b0;
        cyc = 0;
        while (!l2_rd_req && cyc < 20) begin
            tick();
            cyc++;
        end
        check("l2_wait_req", l2_rd_req, 1);
        reset = 1'b0;
        #2;
        check_reset_outputs("midreset");
        drive(0, 1'b0, 2'b11, '0, '0);
        tick();
        reset = 1'b1;
        tick();
        run_txn(tbl[1]);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shared_bus_controller.md
SHARED_BUS_CONTROLLER -- requirements
Module: shared_bus_controller

Interface
- REQ-001: clk  input  1  system clock; all state updates on the rising edge.
- REQ-002: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- REQ-003: cN_req (N in {0,1})  input  1  bus request from core N's L1 controller.
- REQ-004: cN_grant  output  1  bus grant to core N; registered.
- REQ-005: cN_bus_operation  input  2  core N's issued operation: 00 BusRd, 01 BusUpgr, 10 BusRdX, 11 BusNoN.
- REQ-006: cN_bus_address / cN_bus_data  input  32 each  core N's issued address and data; data also serves as snoop-supply data.
- REQ-007: cN_cache_hit  input  1  core N's snoop hit for the currently broadcast address.
- REQ-008: cN_snoop_operation  output  2  operation broadcast to core N; 11 when idle.
- REQ-009: cN_snoop_address / cN_snoop_data  output  32 each  broadcast address, or fill data delivered to core N.
- REQ-010: cN_cache_hit_in  output  2  response code to core N: 00 none, 01 peer-supplied, 10 L2-supplied, 11 upgrade ack.
- REQ-011: l2_rd_req  output  1  L2 read request, held until accepted; l2_address  output  32  latched line address.
- REQ-012: l2_rd_valid  input  1  L2 read data valid; l2_rd_data  input  32  L2 read data.

Function
- REQ-013: FSM states: IDLE, ADDR, SNOOP, RESP, L2RD, DONE, REL.
- REQ-014: IDLE: when any cN_req=1, the winner is chosen; its cN_grant goes to 1 on the next edge; the FSM moves to ADDR.
- REQ-015: At most one cN_grant is 1 in any cycle.
- REQ-016: ADDR: the FSM waits while the requester's operation = 11; otherwise it latches the operation, address and data, then moves to SNOOP.
- REQ-017: SNOOP (1 cycle): the peer's snoop_operation and snoop_address carry the latched values; the requester's snoop_operation stays 11.
- REQ-018: RESP (1 cycle): the FSM samples the peer's cN_cache_hit and cN_bus_data.
- REQ-019: RESP branch, BusUpgr: go to DONE with code 11.
- REQ-020: RESP branch, BusRd/BusRdX with peer hit=1: go to DONE with code 01; requester snoop_data = sampled peer data.
- REQ-021: RESP branch, BusRd/BusRdX with peer hit=0: go to L2RD.
- REQ-022: L2RD: l2_rd_req=1 and l2_address=latched address until l2_rd_valid=1, then go to DONE with code 10 and snoop_data = l2_rd_data.
- REQ-023: l2_rd_valid outside L2RD is ignored.
- REQ-024: DONE: the requester's cN_cache_hit_in shows the code for exactly 1 cycle, with snoop_data valid in the same cycle; then go to REL.
- REQ-025: REL: grant is held until the requester's cN_req=0; grant falls on the next edge, then go to IDLE.
- REQ-026: Back-to-back transactions: there is at least one IDLE cycle between a grant falling and the next grant rising.
- REQ-027: Requester drops cN_req in any state ADDR..L2RD: abort to IDLE on the next edge; grant and l2_rd_req fall; no response code is issued.
- REQ-028: All snoop and response outputs are driven from registers; no combinational path from an input to any output.

Reset
- REQ-029: reset=0 asynchronously forces IDLE, all cN_grant=0, cN_snoop_operation=11, cN_snoop_address=0, cN_snoop_data=0, cN_cache_hit_in=00, l2_rd_req=0, l2_address=0.
- REQ-030: Reset asserted mid-transaction discards the transaction; after release the FSM restarts from IDLE.

Configuration
- REQ-031: Macro ROUND_ROBIN_EN defined: simultaneous requests are granted to the core not granted most recently; the last-grant register resets to core 1, so the first tie goes to core 0.
- REQ-032: ROUND_ROBIN_EN undefined: core 0 always wins ties, and no last-grant register exists.

Verification
- REQ-033: c0 BusRd 0x0000_0040, c1_cache_hit=0, l2_rd_valid 3 cycles after l2_rd_req with data 0xDEAD_BEEF -> c1_snoop_operation=00 for 1 cycle; c0_cache_hit_in=10 with c0_snoop_data=0xDEAD_BEEF for 1 cycle.
- REQ-034: c1 BusRdX 0x100, c0_cache_hit=1, c0_bus_data=0x1234_5678 -> no l2_rd_req; c1_cache_hit_in=01 with c1_snoop_data=0x1234_5678.
- REQ-035: c0 BusUpgr 0x80 -> c1_snoop_operation=01 for 1 cycle; c0_cache_hit_in=11; l2_rd_req stays 0.
- REQ-036: c0_req and c1_req rise together twice -> with ROUND_ROBIN_EN, grants go c0 then c1; without it, c0 both times; never both grants high.
- REQ-037: reset pulled low during L2RD -> l2_rd_req=0 and grants=0 immediately; a subsequent c1 request completes normally.
- REQ-038: c0 drops c0_req in SNOOP -> c0_grant falls next edge; c0_cache_hit_in stays 00.
